// File: rtl/vehicle_control_gen2_pkg.sv
// rtl/vehicle_control_gen2_pkg.sv - shared types and width helper for vehicle_control_gen2
package vehicle_ctrl_pkg;

  typedef enum logic [1:0] {
    GEAR_LOCK    = 2'b00,
    GEAR_PARK    = 2'b01,
    GEAR_REVERSE = 2'b10,
    GEAR_DRIVE   = 2'b11
  } gear_state_e;

  typedef enum logic [1:0] {
    TURN_NONE   = 2'b00,
    TURN_LEFT   = 2'b01,
    TURN_HAZARD = 2'b10,
    TURN_RIGHT  = 2'b11
  } turn_state_e;

  // Mode codes line up with the gear state codes, so a request casts straight to a target state.
  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_PARK    = 2'b01,
    MODE_REVERSE = 2'b10,
    MODE_DRIVE   = 2'b11
  } mode_cmd_e;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'b00,
    ACT_DOWN    = 2'b01,
    ACT_UP      = 2'b10,
    ACT_IGNORED = 2'b11
  } lever_act_e;

  function automatic int gear_width(input int fwd_gears);
    return $clog2(fwd_gears + 1);
  endfunction

endpackage

// File: rtl/vehicle_control_gen2_if.sv
// rtl/vehicle_control_gen2_if.sv - driver-input and lamp/transmission signal bundle
interface vehicle_control_gen2_if #(
  parameter int FWD_GEARS = 5
);
  import vehicle_ctrl_pkg::*;

  localparam int GW = gear_width(FWD_GEARS);

  logic          _switch;
  logic          brake;
  logic          speed_zero;
  logic [1:0]    _gearMode;
  logic [1:0]    _gearShift;
  logic [1:0]    _turnShift;
  logic          hazard_btn;
  logic [1:0]    _gearState;
  logic [GW-1:0] _gearNum;
  logic [1:0]    _turnState;
  logic          lamp_left;
  logic          lamp_right;
  logic          shift_reject;

  modport master (
    output _switch, brake, speed_zero, _gearMode, _gearShift, _turnShift, hazard_btn,
    input  _gearState, _gearNum, _turnState, lamp_left, lamp_right, shift_reject
  );

  modport slave (
    input  _switch, brake, speed_zero, _gearMode, _gearShift, _turnShift, hazard_btn,
    output _gearState, _gearNum, _turnState, lamp_left, lamp_right, shift_reject
  );

endinterface

// File: rtl/vehicle_control_gen2_turn_blinker.sv
// rtl/vehicle_control_gen2_turn_blinker.sv - blink phase and turn inactivity counters
module turn_blinker #(
  parameter int BLINK_HALF   = 4,
  parameter int TURN_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  input  logic active,
  output logic phase_on,
  output logic expired
);

  localparam int PW = $clog2(2 * BLINK_HALF);
  localparam int TW = $clog2(TURN_TIMEOUT + 1);

  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] phase_next;
  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_next;

  // Next counter values; phase_on looks at the next phase so the lamp register lights on entry.
  always_comb begin
    phase_next = '0;
    idle_next  = '0;
    if (active && !restart) begin
      phase_next = (phase_cnt == PW'(2 * BLINK_HALF - 1)) ? '0 : phase_cnt + PW'(1);
      idle_next  = (idle_cnt == TW'(TURN_TIMEOUT - 1)) ? idle_cnt : idle_cnt + TW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      phase_cnt <= phase_next;
      idle_cnt  <= idle_next;
    end
  end

  assign phase_on = active && (phase_next < PW'(BLINK_HALF));
  // The edge that sees this high is the TURN_TIMEOUT-th edge after the restart edge.
  assign expired  = (idle_cnt == TW'(TURN_TIMEOUT - 1));

endmodule

// File: rtl/vehicle_control_gen2.sv
// rtl/vehicle_control_gen2.sv - gear selector and turn-signal controller top level
module vehicle_control_gen2 #(
  parameter int FWD_GEARS    = 5,
  parameter int BLINK_HALF   = 4,
  parameter int TURN_TIMEOUT = 64
) (
  input logic                   clock,
  input logic                   reset_n,
  vehicle_control_gen2_if.slave bus
);
  import vehicle_ctrl_pkg::*;

  localparam int GW = gear_width(FWD_GEARS);

  if (FWD_GEARS < 1 || FWD_GEARS > 15) begin : g_bad_fwd_gears
    $error("FWD_GEARS must be within 1..15");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink_half
    $error("BLINK_HALF must be at least 1");
  end
  if (TURN_TIMEOUT < 1) begin : g_bad_turn_timeout
    $error("TURN_TIMEOUT must be at least 1");
  end

  logic          armed;
  logic [1:0]    mode_q;
  logic [1:0]    shift_q;
  logic [1:0]    turn_q;
  logic          hazard_q;
  logic          mode_edge;
  logic          shift_edge;
  logic          lever_edge;
  logic          hazard_edge;
  lever_act_e    shift_act;
  lever_act_e    lever_act;
  gear_state_e   mode_target;
  gear_state_e   gear_state;
  gear_state_e   gear_next;
  logic [GW-1:0] gear_num;
  logic [GW-1:0] gear_num_next;
  logic          shift_reject;
  logic          reject_next;
  turn_state_e   turn_state;
  turn_state_e   turn_next;
  logic          lamp_left;
  logic          lamp_right;
  logic          restart;
  logic          active;
  logic          phase_on;
  logic          expired;

  // Edge history; the first cycle after reset only samples, so a level held through reset needs a fresh press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed    <= 1'b0;
      mode_q   <= '0;
      shift_q  <= '0;
      turn_q   <= '0;
      hazard_q <= 1'b0;
    end else begin
      armed    <= 1'b1;
      mode_q   <= bus._gearMode;
      shift_q  <= bus._gearShift;
      turn_q   <= bus._turnShift;
      hazard_q <= bus.hazard_btn;
    end
  end

  assign mode_edge   = armed && (mode_q == MODE_HOLD) && (bus._gearMode != MODE_HOLD);
  assign shift_edge  = armed && (shift_q == ACT_NONE) && (bus._gearShift != ACT_NONE);
  assign lever_edge  = armed && (turn_q == ACT_NONE) && (bus._turnShift != ACT_NONE);
  assign hazard_edge = armed && !hazard_q && bus.hazard_btn;
  assign shift_act   = lever_act_e'(bus._gearShift);
  assign lever_act   = lever_act_e'(bus._turnShift);
  assign mode_target = gear_state_e'(bus._gearMode);

  // Gear next-state: ignition, then mode requests, then up/down shifts inside DRIVE.
  always_comb begin
    gear_next     = gear_state;
    gear_num_next = gear_num;
    reject_next   = 1'b0;
    if (!bus._switch) begin
      gear_next     = GEAR_LOCK;
      gear_num_next = '0;
    end else if (gear_state == GEAR_LOCK) begin
      gear_next = GEAR_PARK;
    end else if (mode_edge) begin
      if (mode_target != gear_state) begin
        if (!bus.speed_zero || (gear_state == GEAR_PARK && !bus.brake)) begin
          reject_next = 1'b1;
        end else begin
          gear_next     = mode_target;
          gear_num_next = (mode_target == GEAR_DRIVE) ? GW'(1) : '0;
        end
      end
    end else if (shift_edge) begin
      if (shift_act == ACT_UP) begin
        if (gear_state != GEAR_DRIVE || gear_num == GW'(FWD_GEARS)) reject_next = 1'b1;
        else gear_num_next = gear_num + GW'(1);
      end else if (shift_act == ACT_DOWN) begin
        if (gear_state != GEAR_DRIVE || gear_num == GW'(1)) reject_next = 1'b1;
        else gear_num_next = gear_num - GW'(1);
      end
    end
  end

  // Turn next-state: hazard edge first, then ignition-off clearing, then lever and timeout handling.
  always_comb begin
    turn_next = turn_state;
    restart   = 1'b0;
    if (hazard_edge) begin
      if (turn_state == TURN_HAZARD) begin
        turn_next = TURN_NONE;
      end else begin
        turn_next = TURN_HAZARD;
        restart   = 1'b1;
      end
    end else if (!bus._switch) begin
      if (turn_state != TURN_HAZARD) turn_next = TURN_NONE;
    end else begin
      case (turn_state)
        TURN_NONE: begin
          if (lever_edge && lever_act == ACT_DOWN) begin
            turn_next = TURN_LEFT;
            restart   = 1'b1;
          end else if (lever_edge && lever_act == ACT_UP) begin
            turn_next = TURN_RIGHT;
            restart   = 1'b1;
          end
        end
        TURN_LEFT: begin
          if (lever_edge && lever_act == ACT_DOWN) restart = 1'b1;
          else if (lever_edge && lever_act == ACT_UP) turn_next = TURN_NONE;
          else if (expired) turn_next = TURN_NONE;
        end
        TURN_RIGHT: begin
          if (lever_edge && lever_act == ACT_UP) restart = 1'b1;
          else if (lever_edge && lever_act == ACT_DOWN) turn_next = TURN_NONE;
          else if (expired) turn_next = TURN_NONE;
        end
        default: ;
      endcase
    end
  end

  assign active = (turn_next != TURN_NONE);

  turn_blinker #(
    .BLINK_HALF  (BLINK_HALF),
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_blinker (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .active  (active),
    .phase_on(phase_on),
    .expired (expired)
  );

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gear_state   <= GEAR_LOCK;
      gear_num     <= '0;
      shift_reject <= 1'b0;
      turn_state   <= TURN_NONE;
      lamp_left    <= 1'b0;
      lamp_right   <= 1'b0;
    end else begin
      gear_state   <= gear_next;
      gear_num     <= gear_num_next;
      shift_reject <= reject_next;
      turn_state   <= turn_next;
      lamp_left    <= phase_on && (turn_next == TURN_LEFT || turn_next == TURN_HAZARD);
      lamp_right   <= phase_on && (turn_next == TURN_RIGHT || turn_next == TURN_HAZARD);
    end
  end

  assign bus._gearState   = gear_state;
  assign bus._gearNum     = gear_num;
  assign bus.shift_reject = shift_reject;
  assign bus._turnState   = turn_state;
  assign bus.lamp_left    = lamp_left;
  assign bus.lamp_right   = lamp_right;

endmodule
